// File: rtl/ibex_dummy_instr_checker.sv
// ibex_dummy_instr_checker
//   Retire-side checker for dummy instructions. Dummy words accepted by ID are
//   queued in order; each retiring dummy is decoded, compared against the queue
//   head and kept out of instret. Encoding, mismatch, underflow and overflow
//   faults raise a sticky alert with a sticky cause vector.
// Ports
//   clk_i, rst_ni        clock, async active-low reset
//   chk_en_i             checker enable (mirrors dummy-instruction CSR enable)
//   issue_valid_i/instr  dummy word accepted into ID
//   flush_i              pipeline flush, kills in-flight dummies
//   retire_valid_i/dummy_i/instr_i  retiring instruction and its dummy tag
//   alert_clr_i          clears sticky alert and cause
//   instret_inc_o        combinational: a real (non-dummy) instruction retired
//   dummy_retired_o      a dummy retired cleanly (registered pulse)
//   alert_o, err_cause_o sticky alert, cause {overflow, underflow, mismatch, encoding}
//   outstanding_o        queue occupancy
//   dummy_type_cnt_o     per-type clean-retire counters {AND, DIV, MUL, ADD}
// Configuration
//   IBEX_DUMMY_CHK_STATS_EN builds the saturating per-type counters; otherwise
//   dummy_type_cnt_o is tied to zero.
module ibex_dummy_instr_checker #(
  parameter int unsigned FifoDepth = 2,
  parameter int unsigned StatsCntW = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       chk_en_i,
  input  logic                       issue_valid_i,
  input  logic [31:0]                issue_instr_i,
  input  logic                       flush_i,
  input  logic                       retire_valid_i,
  input  logic                       retire_dummy_i,
  input  logic [31:0]                retire_instr_i,
  input  logic                       alert_clr_i,
  output logic                       instret_inc_o,
  output logic                       dummy_retired_o,
  output logic                       alert_o,
  output logic [3:0]                 err_cause_o,
  output logic [$clog2(FifoDepth):0] outstanding_o,
  output logic [4*StatsCntW-1:0]     dummy_type_cnt_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {CHK_IDLE, CHK_RUN, CHK_ALERT} chk_state_e;

  chk_state_e       r_state;
  logic [31:0]      r_fifo [FifoDepth];
  logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             r_dummy_retired, r_alert;
  logic [3:0]       r_err_cause;

  logic             w_run, w_push, w_pop, w_empty, w_full;
  logic             w_do_push, w_do_pop, w_pop_ok, w_err_any;
  logic [31:0]      w_head;
  logic [6:0]       w_funct7;
  logic [2:0]       w_funct3;
  logic             w_is_add, w_is_mul, w_is_div, w_is_and, w_legal;
  logic [3:0]       w_err;

  // Queue control: activity only while running with the checker enabled.
  assign w_run   = (r_state == CHK_RUN) && chk_en_i;
  assign w_push  = w_run && issue_valid_i;
  assign w_pop   = w_run && retire_valid_i && retire_dummy_i;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CntW'(FifoDepth));
  assign w_head  = r_fifo[r_rd_ptr];

  // Decode the recorded word: a corrupted retire word then shows up as a
  // mismatch rather than also tripping the encoding check.
  assign w_funct7 = w_head[31:25];
  assign w_funct3 = w_head[14:12];
  assign w_is_add = (w_funct7 == 7'h00) && (w_funct3 == 3'b000);
  assign w_is_mul = (w_funct7 == 7'h01) && (w_funct3 == 3'b000);
  assign w_is_div = (w_funct7 == 7'h01) && (w_funct3 == 3'b100);
  assign w_is_and = (w_funct7 == 7'h00) && (w_funct3 == 3'b111);
  assign w_legal  = (w_head[6:0] == 7'h33) && (w_head[11:7] == 5'd0) &&
                    (w_is_add || w_is_mul || w_is_div || w_is_and);

  // Error sources; a same-cycle alert clear masks new errors.
  always_comb begin
    w_err    = 4'b0000;
    w_err[0] = w_pop && !w_empty && !w_legal;
    w_err[1] = w_pop && !w_empty && (w_head != retire_instr_i);
    w_err[2] = w_pop && w_empty;
    w_err[3] = w_push && w_full && !w_pop && !flush_i;
    if (alert_clr_i) w_err = 4'b0000;
  end

  assign w_err_any = |w_err;
  assign w_do_pop  = w_pop && !w_empty;
  assign w_do_push = w_push && !flush_i && (!w_full || w_do_pop);
  assign w_pop_ok  = w_do_pop && !w_err_any;

  // FSM, queue pointers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= CHK_IDLE;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_dummy_retired <= 1'b0;
      r_alert         <= 1'b0;
      r_err_cause     <= 4'b0000;
    end else begin
      r_dummy_retired <= w_pop_ok;
      case (r_state)
        CHK_IDLE: begin
          if (alert_clr_i) r_err_cause <= 4'b0000;
          if (chk_en_i)    r_state     <= CHK_RUN;
        end
        CHK_RUN: begin
          if (!chk_en_i) begin
            r_state  <= CHK_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
          end else begin
            if (w_err_any) begin
              r_state     <= CHK_ALERT;
              r_alert     <= 1'b1;
              r_err_cause <= r_err_cause | w_err;
            end else if (alert_clr_i) begin
              r_err_cause <= 4'b0000;
            end
            // Flush kills everything after any same-cycle pop was checked.
            if (flush_i) begin
              r_wr_ptr <= '0;
              r_rd_ptr <= '0;
              r_count  <= '0;
            end else begin
              r_wr_ptr <= r_wr_ptr + PtrW'(w_do_push);
              r_rd_ptr <= r_rd_ptr + PtrW'(w_do_pop);
              r_count  <= r_count + CntW'(w_do_push) - CntW'(w_do_pop);
            end
          end
        end
        CHK_ALERT: begin
          if (alert_clr_i) begin
            r_state     <= CHK_IDLE;
            r_alert     <= 1'b0;
            r_err_cause <= 4'b0000;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
          end
        end
        default: r_state <= CHK_IDLE;
      endcase
    end
  end

  // Queue storage, no reset needed: entries are only read when occupied.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_fifo[r_wr_ptr] <= issue_instr_i;
  end

`ifdef IBEX_DUMMY_CHK_STATS_EN
  logic [StatsCntW-1:0] r_stat [4];
  logic [3:0]           w_type;

  assign w_type = {w_is_and, w_is_div, w_is_mul, w_is_add};

  // Saturating per-type clean-retire counters, cleared by reset only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) r_stat[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_pop_ok && w_type[i] && (r_stat[i] != {StatsCntW{1'b1}}))
          r_stat[i] <= r_stat[i] + StatsCntW'(1);
      end
    end
  end

  assign dummy_type_cnt_o = {r_stat[3], r_stat[2], r_stat[1], r_stat[0]};
`else
  assign dummy_type_cnt_o = '0;
`endif

  assign instret_inc_o   = retire_valid_i && !retire_dummy_i;
  assign dummy_retired_o = r_dummy_retired;
  assign alert_o         = r_alert;
  assign err_cause_o     = r_err_cause;
  assign outstanding_o   = r_count;

endmodule
